// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//  Shared definitions for the ID/EX issue stage and the EX-stage ALU.
//  Contents:
//   - ALU operation codes (4-bit), common to decoder and ALU
//   - MIPS primary opcode and R-type funct field values
//   - ctrl_t: decoded control bundle carried through the ID/EX register
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_NOR = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;

    // Decoded control bundle
    typedef struct packed {
        logic [3:0] alu_op;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/alu_decode.sv
// -----------------------------------------------------------------------------
// alu_decode
//  Purely combinational MIPS decoder: instruction word plus register-file read
//  data in, ALU control bundle, operands and destination register out.
//  Ports:
//   instr_i    instruction word
//   rs_data_i  value of register rs
//   rt_data_i  value of register rt
//   ctrl_o     alu_op / reg_write / mem_read / mem_write / illegal
//   a_o, b_o   ALU operands (regData1 / regData2)
//   wr_reg_o   destination register number
// -----------------------------------------------------------------------------
module alu_decode
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [31:0]       instr_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    output ctrl_t             ctrl_o,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [REG_AW-1:0] wr_reg_o
);

    logic [5:0]        opcode_s;
    logic [5:0]        funct_s;
    logic [REG_AW-1:0] rt_f_s;
    logic [REG_AW-1:0] rd_f_s;
    logic [DATA_W-1:0] imm_sext_s;
    logic [DATA_W-1:0] imm_zext_s;
    logic [DATA_W-1:0] imm_hi_s;
    logic [DATA_W-1:0] shamt_s;
    logic [DATA_W-1:0] shvar_s;
    ctrl_t             ctrl_raw_s;
    logic [REG_AW-1:0] wr_s;
    // The rs field number is not needed: its value arrives on rs_data_i.
    logic              unused_rs_field_s;

    assign opcode_s   = instr_i[31:26];
    assign funct_s    = instr_i[5:0];
    assign rt_f_s     = REG_AW'(instr_i[20:16]);
    assign rd_f_s     = REG_AW'(instr_i[15:11]);
    assign imm_sext_s = {{(DATA_W-16){instr_i[15]}}, instr_i[15:0]};
    assign imm_zext_s = {{(DATA_W-16){1'b0}}, instr_i[15:0]};
    assign imm_hi_s   = {instr_i[15:0], {(DATA_W-16){1'b0}}};
    assign shamt_s    = {{(DATA_W-5){1'b0}}, instr_i[10:6]};
    assign shvar_s    = {{(DATA_W-5){1'b0}}, rs_data_i[4:0]};
    assign unused_rs_field_s = ^instr_i[25:21];

    // Opcode/funct decode into raw control, operands and destination
    always_comb begin
        ctrl_raw_s.alu_op    = ALU_ADD;
        ctrl_raw_s.reg_write = 1'b0;
        ctrl_raw_s.mem_read  = 1'b0;
        ctrl_raw_s.mem_write = 1'b0;
        ctrl_raw_s.illegal   = 1'b0;
        a_o                  = {DATA_W{1'b0}};
        b_o                  = {DATA_W{1'b0}};
        wr_s                 = {REG_AW{1'b0}};
        case (opcode_s)
            OP_RTYPE: begin
                ctrl_raw_s.reg_write = 1'b1;
                wr_s                 = rd_f_s;
                case (funct_s)
                    FN_ADD, FN_ADDU: begin ctrl_raw_s.alu_op = ALU_ADD; a_o = rs_data_i; b_o = rt_data_i; end
                    FN_SUB, FN_SUBU: begin ctrl_raw_s.alu_op = ALU_SUB; a_o = rs_data_i; b_o = rt_data_i; end
                    FN_AND:  begin ctrl_raw_s.alu_op = ALU_AND; a_o = rs_data_i; b_o = rt_data_i; end
                    FN_OR:   begin ctrl_raw_s.alu_op = ALU_OR;  a_o = rs_data_i; b_o = rt_data_i; end
                    FN_XOR:  begin ctrl_raw_s.alu_op = ALU_XOR; a_o = rs_data_i; b_o = rt_data_i; end
                    FN_NOR:  begin ctrl_raw_s.alu_op = ALU_NOR; a_o = rs_data_i; b_o = rt_data_i; end
                    // Shifts put the shifted value in a, the amount in b
                    FN_SLL:  begin ctrl_raw_s.alu_op = ALU_SLL; a_o = rt_data_i; b_o = shamt_s; end
                    FN_SRL:  begin ctrl_raw_s.alu_op = ALU_SRL; a_o = rt_data_i; b_o = shamt_s; end
                    FN_SRA:  begin ctrl_raw_s.alu_op = ALU_SRA; a_o = rt_data_i; b_o = shamt_s; end
                    FN_SLLV: begin ctrl_raw_s.alu_op = ALU_SLL; a_o = rt_data_i; b_o = shvar_s; end
                    FN_SRLV: begin ctrl_raw_s.alu_op = ALU_SRL; a_o = rt_data_i; b_o = shvar_s; end
                    FN_SRAV: begin ctrl_raw_s.alu_op = ALU_SRA; a_o = rt_data_i; b_o = shvar_s; end
                    default: begin
                        ctrl_raw_s.illegal   = 1'b1;
                        ctrl_raw_s.reg_write = 1'b0;
                        wr_s                 = {REG_AW{1'b0}};
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                ctrl_raw_s.alu_op = ALU_ADD; ctrl_raw_s.reg_write = 1'b1;
                a_o = rs_data_i; b_o = imm_sext_s; wr_s = rt_f_s;
            end
            OP_ANDI: begin
                ctrl_raw_s.alu_op = ALU_AND; ctrl_raw_s.reg_write = 1'b1;
                a_o = rs_data_i; b_o = imm_zext_s; wr_s = rt_f_s;
            end
            OP_ORI: begin
                ctrl_raw_s.alu_op = ALU_OR; ctrl_raw_s.reg_write = 1'b1;
                a_o = rs_data_i; b_o = imm_zext_s; wr_s = rt_f_s;
            end
            OP_XORI: begin
                ctrl_raw_s.alu_op = ALU_XOR; ctrl_raw_s.reg_write = 1'b1;
                a_o = rs_data_i; b_o = imm_zext_s; wr_s = rt_f_s;
            end
            OP_LUI: begin
                // lui is OR of zero with the shifted immediate
                ctrl_raw_s.alu_op = ALU_OR; ctrl_raw_s.reg_write = 1'b1;
                a_o = {DATA_W{1'b0}}; b_o = imm_hi_s; wr_s = rt_f_s;
            end
            OP_LW: begin
                ctrl_raw_s.alu_op = ALU_ADD; ctrl_raw_s.reg_write = 1'b1;
                ctrl_raw_s.mem_read = 1'b1;
                a_o = rs_data_i; b_o = imm_sext_s; wr_s = rt_f_s;
            end
            OP_SW: begin
                ctrl_raw_s.alu_op = ALU_ADD; ctrl_raw_s.reg_write = 1'b0;
                ctrl_raw_s.mem_write = 1'b1;
                a_o = rs_data_i; b_o = imm_sext_s; wr_s = rt_f_s;
            end
            default: begin
                ctrl_raw_s.illegal = 1'b1;
            end
        endcase
    end

    // Writes to $0 are dropped so NOPs become harmless bubbles
    always_comb begin
        ctrl_o           = ctrl_raw_s;
        ctrl_o.reg_write = ctrl_raw_s.reg_write & (wr_s != {REG_AW{1'b0}});
        wr_reg_o         = wr_s;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//  ID/EX issue stage feeding the combinational ALU. Decodes the instruction and
//  register read data (alu_decode), then holds the result in the ID/EX register
//  under a valid/ready handshake with stall and flush.
//  Ports:
//   clk, rst_n                clock, synchronous active-low reset
//   in_valid / in_ready       ID-side handshake (in_ready combinational)
//   instr, rs_data, rt_data   instruction and register-file read data
//   flush                     squash held and incoming instruction
//   out_valid / out_ready     EX-side handshake
//   alu_op, alu_a, alu_b      ALU {Operation, regData1, regData2}
//   wr_reg, reg_write         writeback destination and enable
//   mem_read, mem_write       lw / sw markers
//   st_data                   registered rt_data (store data for sw)
//   illegal                   undecodable instruction flag
// -----------------------------------------------------------------------------
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [REG_AW-1:0] wr_reg,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] st_data,
    output logic              illegal
);

    ctrl_t             dec_ctrl_s;
    logic [DATA_W-1:0] dec_a_s;
    logic [DATA_W-1:0] dec_b_s;
    logic [REG_AW-1:0] dec_wr_s;
    logic              in_ready_s;
    logic              load_s;

    logic              valid_d, valid_q;
    ctrl_t             ctrl_d,  ctrl_q;
    logic [DATA_W-1:0] a_d,     a_q;
    logic [DATA_W-1:0] b_d,     b_q;
    logic [REG_AW-1:0] wr_d,    wr_q;
    logic [DATA_W-1:0] st_d,    st_q;

    alu_decode #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_decode (
        .instr_i   (instr),
        .rs_data_i (rs_data),
        .rt_data_i (rt_data),
        .ctrl_o    (dec_ctrl_s),
        .a_o       (dec_a_s),
        .b_o       (dec_b_s),
        .wr_reg_o  (dec_wr_s)
    );

    assign in_ready_s = ~valid_q | out_ready;
    assign load_s     = in_valid & in_ready_s & ~flush;

    // Next state of the ID/EX register: flush > load > drain > hold
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        a_d     = a_q;
        b_d     = b_q;
        wr_d    = wr_q;
        st_d    = st_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load_s) begin
            valid_d = 1'b1;
            ctrl_d  = dec_ctrl_s;
            a_d     = dec_a_s;
            b_d     = dec_b_s;
            wr_d    = dec_wr_s;
            st_d    = rt_data;
        end else if (out_ready) begin
            // Drain: payload keeps stale values, only valid drops
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // ID/EX pipeline register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '{alu_op: ALU_ADD, reg_write: 1'b0, mem_read: 1'b0,
                         mem_write: 1'b0, illegal: 1'b0};
            a_q     <= {DATA_W{1'b0}};
            b_q     <= {DATA_W{1'b0}};
            wr_q    <= {REG_AW{1'b0}};
            st_q    <= {DATA_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wr_q    <= wr_d;
            st_q    <= st_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = valid_q;
    assign alu_op    = ctrl_q.alu_op;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign wr_reg    = wr_q;
    assign reg_write = ctrl_q.reg_write;
    assign mem_read  = ctrl_q.mem_read;
    assign mem_write = ctrl_q.mem_write;
    assign st_data   = st_q;
    assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//  Scoreboard bench for alu_issue_stage: each accepted instruction pushes its
//  hand-derived expected decode; each cycle the DUT shows a live instruction it
//  is compared against the head of the queue.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wr;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] st;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  wr_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] st_data;
    logic        illegal;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs [16];
    exp_t sb [$];
    logic m_valid;

    alu_issue_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .wr_reg    (wr_reg),
        .reg_write (reg_write),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .st_data   (st_data),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic setv(input int i, input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wr, input logic rw,
                        input logic mr, input logic mw, input logic ill);
        vecs[i].instr = ins;
        vecs[i].rs    = rs;
        vecs[i].rt    = rt;
        vecs[i].e     = '{op: op, a: a, b: b, wr: wr, rw: rw, mr: mr, mw: mw, st: rt, ill: ill};
    endtask

    // One clock: drive, check against scoreboard/model, update model, advance.
    task automatic step(input logic v, input int idx, input logic rdy, input logic fl);
        exp_t e;
        logic acc;
        in_valid  = v;
        instr     = vecs[idx].instr;
        rs_data   = vecs[idx].rs;
        rt_data   = vecs[idx].rt;
        out_ready = rdy;
        flush     = fl;
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || rdy)});
        if (m_valid) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 32'd0, 32'd1);
            end else begin
                e = sb[0];
                check("alu_op",    {28'd0, alu_op},    {28'd0, e.op});
                check("alu_a",     alu_a,              e.a);
                check("alu_b",     alu_b,              e.b);
                check("wr_reg",    {27'd0, wr_reg},    {27'd0, e.wr});
                check("reg_write", {31'd0, reg_write}, {31'd0, e.rw});
                check("mem_read",  {31'd0, mem_read},  {31'd0, e.mr});
                check("mem_write", {31'd0, mem_write}, {31'd0, e.mw});
                check("illegal",   {31'd0, illegal},   {31'd0, e.ill});
                if (e.mw) check("st_data", st_data, e.st);
                if (rdy || fl) void'(sb.pop_front());
            end
        end
        acc = v && (!m_valid || rdy) && !fl;
        if (fl) begin
            m_valid = 1'b0;
            sb.delete();
        end else if (acc) begin
            sb.push_back(vecs[idx].e);
            m_valid = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //   idx instr          rs            rt            op       a             b             wr    rw    mr    mw    ill
        setv(0,  32'h00221820, 32'd5,        32'd7,        4'b0000, 32'd5,        32'd7,        5'd3,  1'b1, 1'b0, 1'b0, 1'b0); // add $3,$1,$2
        setv(1,  32'h000220C3, 32'd0,        32'h80000000, 4'b1010, 32'h80000000, 32'd3,        5'd4,  1'b1, 1'b0, 1'b0, 1'b0); // sra $4,$2,3
        setv(2,  32'h2025FFFC, 32'h10,       32'd0,        4'b0000, 32'h10,       32'hFFFFFFFC, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0); // addi $5,$1,-4
        setv(3,  32'h3425FFFC, 32'h10,       32'd0,        4'b0101, 32'h10,       32'h0000FFFC, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0); // ori $5,$1,0xFFFC
        setv(4,  32'h3C061234, 32'hDEAD,     32'd0,        4'b0101, 32'd0,        32'h12340000, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0); // lui $6,0x1234
        setv(5,  32'hAC220008, 32'h100,      32'hAB,       4'b0000, 32'h100,      32'd8,        5'd2,  1'b0, 1'b0, 1'b1, 1'b0); // sw $2,8($1)
        setv(6,  32'hFC000000, 32'h55,       32'h66,       4'b0000, 32'd0,        32'd0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b1); // opcode 0x3F
        setv(7,  32'h8C67FFF8, 32'h200,      32'd0,        4'b0000, 32'h200,      32'hFFFFFFF8, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0); // lw $7,-8($3)
        setv(8,  32'h012A4022, 32'd20,       32'd3,        4'b0010, 32'd20,       32'd3,        5'd8,  1'b1, 1'b0, 1'b0, 1'b0); // sub $8,$9,$10
        setv(9,  32'h00225827, 32'hF0,       32'h0F,       4'b0110, 32'hF0,       32'h0F,       5'd11, 1'b1, 1'b0, 1'b0, 1'b0); // nor $11,$1,$2
        setv(10, 32'h01CD6004, 32'h25,       32'd1,        4'b1000, 32'd1,        32'd5,        5'd12, 1'b1, 1'b0, 1'b0, 1'b0); // sllv $12,$13,$14
        setv(11, 32'h00000000, 32'd0,        32'h77,       4'b1000, 32'h77,       32'd0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b0); // nop
        setv(12, 32'h384D8001, 32'hFF,       32'd0,        4'b0111, 32'hFF,       32'h8001,     5'd13, 1'b1, 1'b0, 1'b0, 1'b0); // xori $13,$2,0x8001
        setv(13, 32'h00000001, 32'd1,        32'd2,        4'b0000, 32'd0,        32'd0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b1); // bad funct
        setv(14, 32'h3041F0F0, 32'h1234,     32'd0,        4'b0100, 32'h1234,     32'hF0F0,     5'd1,  1'b1, 1'b0, 1'b0, 1'b0); // andi $1,$2,0xF0F0
        setv(15, 32'h00A41807, 32'hFFFFFFE3, 32'h80,       4'b1010, 32'h80,       32'd3,        5'd3,  1'b1, 1'b0, 1'b0, 1'b0); // srav $3,$4,$5

        // Reset held two cycles while ID offers an instruction
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        instr     = vecs[0].instr;
        rs_data   = vecs[0].rs;
        rt_data   = vecs[0].rt;
        flush     = 1'b0;
        out_ready = 1'b1;
        m_valid   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_alu_op",    {28'd0, alu_op},    32'd0);
        check("rst_reg_write", {31'd0, reg_write}, 32'd0);
        check("rst_alu_a",     alu_a,              32'd0);
        check("rst_alu_b",     alu_b,              32'd0);
        check("rst_illegal",   {31'd0, illegal},   32'd0);
        rst_n = 1'b1;

        // Back-to-back decode of the first seven vectors
        for (int i = 0; i <= 6; i++) step(1'b1, i, 1'b1, 1'b0);

        // Hold: EX stalls three cycles while ID keeps offering vec 8
        step(1'b1, 7, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8, 1'b0, 1'b0);
        step(1'b1, 8, 1'b1, 1'b0);

        // Flush with a new offer: vec 9 must be dropped
        step(1'b1, 9, 1'b1, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0);

        // Flush while EX is stalled squashes the held instruction
        step(1'b1, 10, 1'b1, 1'b0);
        step(1'b0, 0,  1'b0, 1'b1);
        step(1'b0, 0,  1'b1, 1'b0);

        // Remaining vectors with pseudo-random EX stalls
        for (int i = 11; i <= 15; i++) begin
            step(1'b1, i, 1'b1, 1'b0);
            if ($urandom_range(1) == 1) step(1'b1, (i + 1) % 16, 1'b0, 1'b0);
        end

        // Drain
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0);
        check("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
